// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8-bit UART transmitter, even parity, one stop bit, with input buffer
// Define UART_TX_FIFO_EN for a 4-entry FIFO buffer; otherwise a single holding register.
module uart_tx #(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_out,
    output logic       busy
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] bit_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_data;
    logic             parity_bit;

    logic       buf_empty;
    logic       buf_full;
    logic [7:0] buf_head;
    logic       push;
    logic       pop;
    logic       bit_done;

    assign tx_ready = !buf_full;
    assign push     = tx_valid && tx_ready;
    assign bit_done = (bit_cnt == CNT_LAST);
    assign pop      = !buf_empty && ((state == IDLE) || ((state == STOP) && bit_done));
    assign busy     = (state != IDLE) || !buf_empty;

`ifdef UART_TX_FIFO_EN
    logic [7:0] fifo_mem [4];
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic [2:0] count;

    assign buf_full  = (count == 3'd4);
    assign buf_empty = (count == 3'd0);
    assign buf_head  = fifo_mem[rd_ptr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            count  <= 3'd0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clock) begin
        if (push) fifo_mem[wr_ptr] <= tx_data;
    end
`else
    logic [7:0] hold_data;
    logic       hold_full;

    assign buf_full  = hold_full;
    assign buf_empty = !hold_full;
    assign buf_head  = hold_data;

    // push needs an empty register and pop a full one, so they never coincide.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold_data <= 8'd0;
            hold_full <= 1'b0;
        end else if (push) begin
            hold_data <= tx_data;
            hold_full <= 1'b1;
        end else if (pop) begin
            hold_full <= 1'b0;
        end
    end
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            tx_out     <= 1'b1;
            bit_cnt    <= '0;
            bit_idx    <= 3'd0;
            shift_data <= 8'd0;
            parity_bit <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    tx_out  <= 1'b1;
                    bit_cnt <= '0;
                    if (pop) begin
                        shift_data <= buf_head;
                        parity_bit <= ^buf_head;
                        tx_out     <= 1'b0;
                        state      <= START;
                    end
                end
                START: begin
                    if (bit_done) begin
                        bit_cnt <= '0;
                        bit_idx <= 3'd0;
                        tx_out  <= shift_data[0];
                        state   <= DATA;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        bit_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            bit_idx <= 3'd0;
                            tx_out  <= parity_bit;
                            state   <= PARITY;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx_out  <= shift_data[bit_idx + 3'd1];
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                PARITY: begin
                    if (bit_done) begin
                        bit_cnt <= '0;
                        tx_out  <= 1'b1;
                        state   <= STOP;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        bit_cnt <= '0;
                        // Chain straight into the next start bit when a byte is waiting.
                        if (pop) begin
                            shift_data <= buf_head;
                            parity_bit <= ^buf_head;
                            tx_out     <= 1'b0;
                            state      <= START;
                        end else begin
                            tx_out <= 1'b1;
                            state  <= IDLE;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    tx_out  <= 1'b1;
                    bit_cnt <= '0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx with a line-level receiver model
module tb_uart_tx;

    localparam int CPB   = 217;
    localparam int FRAME = 11 * CPB;

    logic       clock;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_out;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] exp_q[$];
    int         start_q[$];
    logic [7:0] rx_last;
    logic       rx_err;

    typedef struct {
        logic [7:0]  data;
        logic [10:0] seq;
    } vec_t;
    vec_t tbl[5];

    uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clock    (clock),
        .reset    (reset),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_out   (tx_out),
        .busy     (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h at cycle %0d", name, got, exp, cyc);
        end
    endtask

    // Receiver model: each frame is the spec's 11-bit pattern, every cycle of every bit checked.
    initial begin : monitor
        logic [7:0]  d;
        logic [10:0] bits;
        logic [7:0]  rx;
        logic        ab;
        logic        mis;
        logic        got;
        logic        stop_bad;
        forever begin
            @(negedge clock);
            if (!reset && tx_out === 1'b0) begin
                ab = 1'b0;
                stop_bad = 1'b0;
                rx = 8'd0;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_frame got=start bit expected=idle at cycle %0d", cyc);
                    d = 8'd0;
                end else begin
                    d = exp_q.pop_front();
                end
                bits = {1'b1, ^d, d, 1'b0};
                start_q.push_back(cyc);
                for (int k = 0; k < 11 && !ab; k++) begin
                    mis = 1'b0;
                    got = bits[k];
                    for (int j = 0; j < CPB && !ab; j++) begin
                        if (k != 0 || j != 0) @(negedge clock);
                        if (reset) begin
                            ab = 1'b1;
                        end else begin
                            if (tx_out !== bits[k]) begin
                                mis = 1'b1;
                                got = tx_out;
                            end
                            if (j == CPB / 2 && k >= 1 && k <= 8) rx[k-1] = tx_out;
                            if (j == CPB / 2 && k == 10) stop_bad = (tx_out !== 1'b1);
                        end
                    end
                    if (!ab) begin
                        total++;
                        if (mis) begin
                            bad++;
                            $display("FAIL frame_bit byte=%0h bit=%0d got=%0b expected=%0b", d, k, got, bits[k]);
                        end
                    end
                end
                if (!ab) begin
                    rx_last = rx;
                    rx_err  = stop_bad;
                    total++;
                    if (rx !== d || stop_bad) begin
                        bad++;
                        $display("FAIL rx_byte got=%0h stop_err=%0b expected=%0h", rx, stop_bad, d);
                    end
                end
            end
        end
    end

    // Called at a negedge; holds tx_valid high until all n bytes are accepted.
    task automatic push_bytes(input logic [7:0] d[6], input int n, output int acc[6]);
        int   i = 0;
        int   guard = 0;
        logic r;
        for (int k = 0; k < 6; k++) acc[k] = 0;
        while (i < n && guard < 20 * FRAME) begin
            tx_data  = d[i];
            tx_valid = 1'b1;
            r = tx_ready;
            @(posedge clock);
            @(negedge clock);
            guard++;
            if (r) begin
                exp_q.push_back(d[i]);
                acc[i] = cyc;
                i++;
            end
        end
        tx_valid = 1'b0;
        if (i < n) begin
            total++;
            bad++;
            $display("FAIL push_timeout got=%0d accepted expected=%0d", i, n);
        end
    endtask

    task automatic wait_idle(output int fall);
        int g = 0;
        while (busy !== 1'b0 && g < 20 * FRAME) begin
            @(negedge clock);
            g++;
        end
        if (busy !== 1'b0) begin
            total++;
            bad++;
            $display("FAIL idle_timeout got=busy expected=idle");
        end
        fall = cyc;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clock);
    endtask

    initial begin : main
        logic [7:0] d[6];
        int         acc[6];
        int         fall;
        int         n0;
        int         errs;
        int         gap;

        tbl[0] = '{8'hA5, 11'b01010010101};
        tbl[1] = '{8'h01, 11'b01000000011};
        tbl[2] = '{8'h00, 11'b00000000001};
        tbl[3] = '{8'hFF, 11'b01111111101};
        tbl[4] = '{8'h80, 11'b00000000111};

        reset    = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        for (int k = 0; k < 6; k++) d[k] = 8'h00;
        repeat (3) @(negedge clock);
        chk("rst_tx_out", {31'd0, tx_out}, 1);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_tx_ready", {31'd0, tx_ready}, 1);
        reset = 1'b0;

        // Idle line with tx_valid low but tx_data wiggling.
        errs = 0;
        for (int i = 0; i < 5000; i++) begin
            tx_data = 8'($urandom_range(0, 255));
            @(negedge clock);
            if (tx_out !== 1'b1 || busy !== 1'b0 || tx_ready !== 1'b1) errs++;
        end
        chk("idle_line", errs, 0);

        for (int i = 0; i < 5; i++) begin
            d[0] = tbl[i].data;
            push_bytes(d, 1, acc);
            n0 = acc[0];
            chk("lat_pre", {31'd0, tx_out}, 1);
            chk("busy_buffered", {31'd0, busy}, 1);
            @(negedge clock);
            chk("lat_start", {31'd0, tx_out}, 0);
            for (int k = 0; k < 11; k++) begin
                wait_until(n0 + 1 + k * CPB + CPB / 2);
                chk("tbl_bit", {31'd0, tx_out}, {31'd0, tbl[i].seq[10-k]});
            end
            wait_idle(fall);
            chk("tbl_busy_fall", fall - (n0 + 1), FRAME);
        end

        // Back-to-back frames with tx_valid held high.
        start_q.delete();
        d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33;
        push_bytes(d, 3, acc);
`ifdef UART_TX_FIFO_EN
        chk("b2b_accept_fast", acc[2] - acc[0], 2);
`else
        chk("b2b_stall", acc[1] - acc[0], 2);
        chk("b2b_third", acc[2] - acc[0], FRAME + 2);
`endif
        wait_idle(fall);
        chk("b2b_total_len", fall - (acc[0] + 1), 3 * FRAME);
        chk("b2b_frames", start_q.size(), 3);
        if (start_q.size() == 3) begin
            chk("b2b_gap01", start_q[1] - start_q[0], FRAME);
            chk("b2b_gap12", start_q[2] - start_q[1], FRAME);
        end

        // Six bytes pushed continuously from idle.
        for (int k = 0; k < 6; k++) d[k] = 8'($urandom_range(0, 255));
        push_bytes(d, 6, acc);
`ifdef UART_TX_FIFO_EN
        chk("fifo_fill", acc[4] - acc[0], 4);
        chk("fifo_sixth", acc[5] - acc[0], FRAME + 2);
`else
        chk("hold_sixth", acc[5] - acc[0], 4 * FRAME + 2);
`endif
        wait_idle(fall);
        chk("six_drain", exp_q.size(), 0);

        // Random bytes with random gaps; the receiver model checks every frame.
        for (int i = 0; i < 6; i++) begin
            d[0] = 8'($urandom_range(0, 255));
            push_bytes(d, 1, acc);
            gap = $urandom_range(0, 1500);
            for (int j = 0; j < gap; j++) begin
                tx_data = 8'($urandom_range(0, 255));
                @(negedge clock);
            end
        end
        wait_idle(fall);
        chk("rand_drain", exp_q.size(), 0);

        // Reset in the middle of a 0x3C frame.
        d[0] = 8'h3C;
        push_bytes(d, 1, acc);
        wait_until(acc[0] + 1 + 1000);
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_tx_out", {31'd0, tx_out}, 1);
        chk("midrst_busy", {31'd0, busy}, 0);
        chk("midrst_ready", {31'd0, tx_ready}, 1);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        errs = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            if (tx_out !== 1'b1 || busy !== 1'b0) errs++;
        end
        chk("post_rst_quiet", errs, 0);

        rx_last = 8'h00;
        rx_err  = 1'b1;
        d[0] = 8'h3C;
        push_bytes(d, 1, acc);
        wait_idle(fall);
        chk("loop_rx", {24'd0, rx_last}, 32'h3C);
        chk("loop_err", {31'd0, rx_err}, 0);
        chk("loop_len", fall - (acc[0] + 1), FRAME);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
